// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
//   FP_W/EXP_W/MANT_W : word layout {sign, exp[7:0], mant[22:0]}
//   SP/HP_EXP_BIAS    : exponent bias for single and half precision
//   fp_word, fp_flags : operand/result word and {ovf, unf, inx} status
//   MODE_HALF/SINGLE  : precision select encoding
package fpu_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned MANT_W      = 23;
    localparam int unsigned SP_EXP_BIAS = 127;
    localparam int unsigned HP_EXP_BIAS = 15;

    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_word;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fp_flags;

endpackage

// File: rtl/fp_mul_scheduler_if.sv
// Request/response bus of the shared multiplier scheduler.
//   master : FPU issue side (drives requests, observes responses)
//   slave  : fp_mul_scheduler
//   req_*  : per-port valid/ready/mode and operands (port i at [32i+31:32i])
//   resp_* : shared response channel tagged with requester ID; busy = op in flight
interface fp_mul_scheduler_if
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);
    localparam int unsigned IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      req_mode;
    logic [FP_W*NUM_REQ-1:0] req_op_a;
    logic [FP_W*NUM_REQ-1:0] req_op_b;
    logic                    cfg_round_mode;
    logic                    resp_valid;
    logic [IDW-1:0]          resp_id;
    logic [FP_W-1:0]         resp_result;
    logic [2:0]              resp_flags;
    logic                    busy;

    modport master (
        output req_valid, req_mode, req_op_a, req_op_b, cfg_round_mode,
        input  req_ready, resp_valid, resp_id, resp_result, resp_flags, busy
    );

    modport slave (
        input  req_valid, req_mode, req_op_a, req_op_b, cfg_round_mode,
        output req_ready, resp_valid, resp_id, resp_result, resp_flags, busy
    );

endinterface

// File: rtl/fp_multiplier.sv
// Three-stage FP multiplier (normal numbers, flush-to-zero).
//   clk, rst    : clock, synchronous active-high reset
//   mode_fp     : 0=half, 1=single; unregistered, used in stages 2 and 3
//   round_mode  : 0=round-to-nearest-even, 1=truncate
//   op_a, op_b  : operands, captured at the end of the presentation cycle
//   result/flags: stable three cycles after presentation
// Half operands keep the 8/23 field layout: exp holds the 5-bit half
// exponent, mant[22:13] holds the 10-bit half fraction.
module fp_multiplier
    import fpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    mode_fp,
    input  logic    round_mode,
    input  fp_word  op_a,
    input  fp_word  op_b,
    output fp_word  result,
    output fp_flags flags
);
    fp_word             s1_a, s1_b;
    logic               s2_sign, s2_zero;
    logic signed [10:0] s2_exp;
    logic [47:0]        s2_prod;

    logic               half_c;
    logic [23:0]        ma_c, mb_c;
    logic signed [10:0] bias_c, exp_c;

    logic [47:0]        norm_c;
    logic [22:0]        kept_c;
    logic [23:0]        inc_c, sum_c;
    logic               guard_c, sticky_c, lsb_c, rnd_up_c;
    logic signed [10:0] e_c, emax_c;
    fp_word             res_c;
    fp_flags            flg_c;

    assign half_c = (mode_fp == MODE_HALF);

    // Stage 2: significand product and unbiased-sum exponent
    always_comb begin
        ma_c = {1'b1, s1_a.mant};
        mb_c = {1'b1, s1_b.mant};
        if (half_c) begin
            ma_c[12:0] = '0;
            mb_c[12:0] = '0;
        end
        bias_c = half_c ? 11'sd15 : 11'sd127;
        exp_c  = $signed({3'b000, s1_a.exp}) + $signed({3'b000, s1_b.exp}) - bias_c;
    end

    // Stage 3: normalise, round at the precision's LSB, classify
    always_comb begin
        norm_c = s2_prod[47] ? s2_prod : {s2_prod[46:0], 1'b0};
        if (half_c) begin
            kept_c   = {norm_c[46:37], 13'b0};
            guard_c  = norm_c[36];
            sticky_c = |norm_c[35:0];
            lsb_c    = norm_c[37];
            inc_c    = 24'h002000;
            emax_c   = 11'sd31;
        end else begin
            kept_c   = norm_c[46:24];
            guard_c  = norm_c[23];
            sticky_c = |norm_c[22:0];
            lsb_c    = norm_c[24];
            inc_c    = 24'h000001;
            emax_c   = 11'sd255;
        end
        rnd_up_c = !round_mode && guard_c && (sticky_c || lsb_c);
        sum_c    = {1'b0, kept_c} + (rnd_up_c ? inc_c : 24'd0);
        // A rounding carry leaves the fraction all-zero and bumps the exponent
        e_c      = s2_exp + $signed({10'd0, s2_prod[47]}) + $signed({10'd0, sum_c[23]});

        res_c = '{sign: s2_sign, exp: '0, mant: '0};
        flg_c = '{ovf: 1'b0, unf: 1'b0, inx: 1'b0};
        if (s2_zero) begin
            res_c.exp = '0;
        end else if (e_c >= emax_c) begin
            res_c.exp = emax_c[7:0];
            flg_c.ovf = 1'b1;
        end else if (e_c <= 11'sd0) begin
            flg_c.unf = 1'b1;
        end else begin
            res_c.exp  = e_c[7:0];
            res_c.mant = sum_c[22:0];
            flg_c.inx  = guard_c | sticky_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b1;
            s2_exp  <= '0;
            s2_prod <= '0;
            result  <= '0;
            flags   <= '0;
        end else begin
            s1_a    <= op_a;
            s1_b    <= op_b;
            s2_sign <= s1_a.sign ^ s1_b.sign;
            s2_zero <= (s1_a.exp == '0) || (s1_b.exp == '0);
            s2_exp  <= exp_c;
            s2_prod <= {24'd0, ma_c} * {24'd0, mb_c};
            result  <= res_c;
            flags   <= flg_c;
        end
    end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one fp_multiplier between NUM_REQ ports.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fp_mul_scheduler_if (requests in, tagged responses out)
// The multiplier precision is held in cur_mode_q; a request of the other
// precision is granted only once the tag pipe has drained.
module fp_mul_scheduler
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    fp_mul_scheduler_if.slave  bus
);
    localparam int unsigned IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]     ptr_q;
    logic               cur_mode_q;
    logic [MUL_LAT-1:0] tv_q;
    logic [IDW-1:0]     tid_q [MUL_LAT];

    logic               found_c, grant_c, busy_c, cand_mode_c;
    logic [IDW-1:0]     cand_c;
    fp_word             mul_a_c, mul_b_c, mul_res;
    fp_flags            mul_flg;

    assign busy_c = |tv_q;

    // Candidate: first valid port at or after ptr_q, wrapping to port 0
    always_comb begin
        found_c = 1'b0;
        cand_c  = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found_c && bus.req_valid[j] && (IDW'(j) >= ptr_q)) begin
                found_c = 1'b1;
                cand_c  = IDW'(j);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found_c && bus.req_valid[j] && (IDW'(j) < ptr_q)) begin
                found_c = 1'b1;
                cand_c  = IDW'(j);
            end
        end
    end

    // Grant gate and operand mux; idle cycles present zero operands
    always_comb begin
        cand_mode_c = 1'b0;
        mul_a_c     = '0;
        mul_b_c     = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (IDW'(j) == cand_c) cand_mode_c = bus.req_mode[j];
        end
        grant_c = found_c && !rst && ((cand_mode_c == cur_mode_q) || !busy_c);
        if (grant_c) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (IDW'(j) == cand_c) begin
                    mul_a_c = bus.req_op_a[j*FP_W +: FP_W];
                    mul_b_c = bus.req_op_b[j*FP_W +: FP_W];
                end
            end
        end
        bus.req_ready = grant_c ? (NUM_REQ'(1) << cand_c) : '0;
    end

    // Pointer, precision and tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            cur_mode_q <= MODE_SINGLE;
            tv_q       <= '0;
            for (int k = 0; k < int'(MUL_LAT); k++) tid_q[k] <= '0;
        end else begin
            tv_q     <= {tv_q[MUL_LAT-2:0], grant_c};
            tid_q[0] <= cand_c;
            for (int k = 1; k < int'(MUL_LAT); k++) tid_q[k] <= tid_q[k-1];
            if (grant_c) begin
                ptr_q      <= (cand_c == IDW'(NUM_REQ-1)) ? '0 : cand_c + IDW'(1);
                cur_mode_q <= cand_mode_c;
            end
        end
    end

    fp_multiplier u_mul (
        .clk        (clk),
        .rst        (rst),
        .mode_fp    (cur_mode_q),
        .round_mode (bus.cfg_round_mode),
        .op_a       (mul_a_c),
        .op_b       (mul_b_c),
        .result     (mul_res),
        .flags      (mul_flg)
    );

    assign bus.resp_valid  = tv_q[MUL_LAT-1];
    assign bus.resp_id     = tid_q[MUL_LAT-1];
    assign bus.resp_result = mul_res;
    assign bus.resp_flags  = mul_flg;
    assign bus.busy        = busy_c;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler (NUM_REQ=2, MUL_LAT=3).
module tb_fp_mul_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fp_mul_scheduler_if #(.NUM_REQ(2)) bus ();

    fp_mul_scheduler #(.NUM_REQ(2), .MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.req_valid = 2'b00;
        bus.req_mode  = 2'b11;
        bus.req_op_a  = '0;
        bus.req_op_b  = '0;
    endtask

    task automatic drive(input int p, input logic v, input logic m,
                         input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[p]         = v;
        bus.req_mode[p]          = m;
        bus.req_op_a[p*32 +: 32] = a;
        bus.req_op_b[p*32 +: 32] = b;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h40000000, 32'h40400000);
        tick();
        @(negedge clk);
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        total++; if (bus.resp_id !== 1'b0) begin bad++; $display("FAIL reset_resp_id: got %b want 0", bus.resp_id); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tick();
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_single_ops();
        int          vp [6] = '{0, 1, 0, 1, 0, 1};
        logic [31:0] va [6] = '{32'h40000000, 32'h3FC00000, 32'h7F000000,
                                32'h3F800001, 32'hC0000000, 32'h00800000};
        logic [31:0] vb [6] = '{32'h40400000, 32'h3FC00000, 32'h7F000000,
                                32'h3F800001, 32'h40400000, 32'h00800000};
        logic [31:0] vr [6] = '{32'h40C00000, 32'h40100000, 32'h7F800000,
                                32'h3F800002, 32'hC0C00000, 32'h00000000};
        logic [2:0]  vf [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b000, 3'b010};
        logic [1:0]  rdy;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(vp[i], 1'b1, 1'b1, va[i], vb[i]);
            rdy = (vp[i] == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            total++; if (bus.req_ready !== rdy) begin bad++; $display("FAIL single%0d_ready: got %b want %b", i, bus.req_ready, rdy); end
            tick();
            idle_all();
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c < 3) begin
                    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL single%0d_early c%0d: got %b want 0", i, c, bus.resp_valid); end
                    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single%0d_busy c%0d: got %b want 1", i, c, bus.busy); end
                end else begin
                    total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL single%0d_valid: got %b want 1", i, bus.resp_valid); end
                    total++; if (bus.resp_id !== vp[i][0]) begin bad++; $display("FAIL single%0d_id: got %b want %b", i, bus.resp_id, vp[i][0]); end
                    total++; if (bus.resp_result !== vr[i]) begin bad++; $display("FAIL single%0d_result: got %h want %h", i, bus.resp_result, vr[i]); end
                    total++; if (bus.resp_flags !== vf[i]) begin bad++; $display("FAIL single%0d_flags: got %b want %b", i, bus.resp_flags, vf[i]); end
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  rdy;
        logic        eid;
        logic [31:0] eres;
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            if (c < 8) begin
                drive(0, 1'b1, 1'b1, 32'h40000000, 32'h40400000);
                drive(1, 1'b1, 1'b1, 32'h3FC00000, 32'h3FC00000);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (c < 8) begin
                rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                total++; if (bus.req_ready !== rdy) begin bad++; $display("FAIL b2b_ready c%0d: got %b want %b", c, bus.req_ready, rdy); end
            end
            if (c >= 3 && c <= 10) begin
                eid  = ((c - 3) % 2 == 1);
                eres = eid ? 32'h40100000 : 32'h40C00000;
                total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c%0d: got %b want 1", c, bus.resp_valid); end
                total++; if (bus.resp_id !== eid) begin bad++; $display("FAIL b2b_id c%0d: got %b want %b", c, bus.resp_id, eid); end
                total++; if (bus.resp_result !== eres) begin bad++; $display("FAIL b2b_result c%0d: got %h want %h", c, bus.resp_result, eres); end
            end else begin
                total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_novalid c%0d: got %b want 0", c, bus.resp_valid); end
            end
            if (c >= 1 && c <= 10) begin
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy c%0d: got %b want 1", c, bus.busy); end
            end
            if (c == 11) begin
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", bus.busy); end
            end
            tick();
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            idle_all();
            if (c == 0) drive(0, 1'b1, 1'b1, 32'h40000000, 32'h40400000);
            if (c >= 1 && c <= 4) drive(1, 1'b1, 1'b0, 32'h07C00000, 32'h07C00000);
            @(negedge clk);
            if (c == 0) begin
                total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mode_ready c0: got %b want 01", bus.req_ready); end
            end
            if (c >= 1 && c <= 3) begin
                total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL mode_hold c%0d: got %b want 00", c, bus.req_ready); end
            end
            if (c == 3) begin
                total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mode_p0_valid: got %b want 1", bus.resp_valid); end
                total++; if (bus.resp_id !== 1'b0) begin bad++; $display("FAIL mode_p0_id: got %b want 0", bus.resp_id); end
                total++; if (bus.resp_result !== 32'h40C00000) begin bad++; $display("FAIL mode_p0_result: got %h want 40c00000", bus.resp_result); end
            end
            if (c == 4) begin
                total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL mode_accept c4: got %b want 10", bus.req_ready); end
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mode_drained c4: got %b want 0", bus.busy); end
            end
            if (c == 5 || c == 6) begin
                total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL mode_gap c%0d: got %b want 0", c, bus.resp_valid); end
            end
            if (c == 7) begin
                total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mode_p1_valid: got %b want 1", bus.resp_valid); end
                total++; if (bus.resp_id !== 1'b1) begin bad++; $display("FAIL mode_p1_id: got %b want 1", bus.resp_id); end
                total++; if (bus.resp_result !== 32'h08100000) begin bad++; $display("FAIL mode_half_result: got %h want 08100000", bus.resp_result); end
                total++; if (bus.resp_flags !== 3'b000) begin bad++; $display("FAIL mode_half_flags: got %b want 000", bus.resp_flags); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            idle_all();
            rst = (c == 2);
            if (c == 0) drive(1, 1'b1, 1'b1, 32'h40000000, 32'h40400000);
            if (c == 1) drive(0, 1'b1, 1'b1, 32'h3FC00000, 32'h3FC00000);
            if (c >= 2 && c <= 4) begin
                drive(0, 1'b1, 1'b1, 32'h40000000, 32'h40400000);
                drive(1, 1'b1, 1'b1, 32'h3FC00000, 32'h3FC00000);
            end
            @(negedge clk);
            if (c == 0) begin
                total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL rmf_ready c0: got %b want 10", bus.req_ready); end
            end
            if (c == 1) begin
                total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmf_ready c1: got %b want 01", bus.req_ready); end
            end
            if (c == 2) begin
                total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rmf_ready_in_rst: got %b want 00", bus.req_ready); end
            end
            if (c == 3) begin
                total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rmf_first_grant: got %b want 01", bus.req_ready); end
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmf_busy: got %b want 0", bus.busy); end
            end
            if (c == 4) begin
                total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL rmf_second_grant: got %b want 10", bus.req_ready); end
            end
            if (c >= 3 && c <= 5) begin
                total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rmf_dropped c%0d: got %b want 0", c, bus.resp_valid); end
            end
            if (c == 6 || c == 7) begin
                total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL rmf_post_valid c%0d: got %b want 1", c, bus.resp_valid); end
                total++; if (bus.resp_id !== (c == 7)) begin bad++; $display("FAIL rmf_post_id c%0d: got %b want %b", c, bus.resp_id, (c == 7)); end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.cfg_round_mode = 1'b0;
        idle_all();
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_mode_switch();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
